// File: rtl/aes_pkg.sv
// Shared AES definitions for the AddRoundKey stage and its key store.
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int STATE_W = 128;

  typedef enum logic {
    IDLE,
    RUN
  } aes_state_t;

  typedef logic [3:0] rk_idx_t;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: NR+1 keys, one valid bit each, asynchronous read.
// Reads see the stored value before any write in the same cycle.
module aes_rk_store
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_we,
  input  rk_idx_t            key_addr,
  input  logic [STATE_W-1:0] key_wdata,
  input  logic               key_clear,
  input  rk_idx_t            rd_idx,
  output logic [STATE_W-1:0] rd_key,
  output logic               key_ready
);

  localparam rk_idx_t NR_IDX = rk_idx_t'(NR);

  logic [STATE_W-1:0] key_q [NR+1];
  logic [NR:0]        valid_q;
  logic               wr_en;

  // key_clear overrides a simultaneous write; out-of-range addresses are ignored
  assign wr_en = key_we && !key_clear && (key_addr <= NR_IDX);

  // key data needs no reset: the valid bits alone decide usability
  always_ff @(posedge clk) begin
    if (wr_en) key_q[key_addr] <= key_wdata;
  end

  // valid bits: cleared by reset or key_clear, set per write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (key_clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[key_addr] <= 1'b1;
    end
  end

  assign key_ready = &valid_q;

  // asynchronous read port, zero for indices beyond the store
  always_comb begin
    rd_key = '0;
    if (rd_idx <= NR_IDX) rd_key = key_q[rd_idx];
  end

endmodule

// File: rtl/aes_add_round_key.sv
// Registered AES-128 AddRoundKey stage with round counter and key store.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an in_first beat; rnd = 0
// RUN   | inside a block; rnd = round index of the next beat (1..NR)
module aes_add_round_key
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_we,
  input  logic [3:0]         key_addr,
  input  logic [STATE_W-1:0] key_wdata,
  input  logic               key_clear,
  output logic               key_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic [3:0]         out_round,
  output logic               out_final,
  output logic               err
);

  localparam rk_idx_t NR_IDX = rk_idx_t'(NR);

  aes_state_t         state;
  rk_idx_t            rnd;
  rk_idx_t            rd_idx;
  logic [STATE_W-1:0] rd_key;
  logic               accept;
  logic               produce;

  aes_rk_store #(.NR(NR)) u_rk_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_wdata (key_wdata),
    .key_clear (key_clear),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key),
    .key_ready (key_ready)
  );

  // a first beat in IDLE stalls until every key is present; key_clear blocks all beats
  assign in_ready = (!out_valid || out_ready)
                  && !(state == IDLE && !key_ready && in_first)
                  && !key_clear;
  assign accept   = in_valid && in_ready;

  // a first beat always restarts at round 0, otherwise the running round is used
  assign rd_idx  = (state == RUN && !in_first) ? rnd : '0;
  // a non-first beat in IDLE is consumed but produces nothing
  assign produce = accept && (in_first || state == RUN);

  // round FSM, output register and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      out_valid <= 1'b0;
      out_state <= '0;
      out_round <= '0;
      out_final <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept && (in_first ? (state == RUN) : (state == IDLE));

      if (produce) begin
        out_valid <= 1'b1;
        out_state <= in_state ^ rd_key;
        out_round <= rd_idx;
        out_final <= (rd_idx == NR_IDX);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (key_clear) begin
        state <= IDLE;
        rnd   <= '0;
      end else if (accept) begin
        if (in_first) begin
          state <= RUN;
          rnd   <= rk_idx_t'(1);
        end else if (state == RUN) begin
          if (rnd == NR_IDX) begin
            state <= IDLE;
            rnd   <= '0;
          end else begin
            rnd <= rnd + rk_idx_t'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/aes_add_round_key.md
# aes_add_round_key

Registered AddRoundKey stage with an on-chip round-key store for AES-128 encryption. It sits directly downstream of the MixColumns stage and also takes the round-0 plaintext. Each accepted 128-bit state is XORed with the round key for the current round, and the result goes out through a one-deep valid/ready output register. A round counter selects the key and tags each result, so the controller upstream needs no key bookkeeping.

## Interface
- NR, default 10: number of AES rounds. Round keys are indexed 0..NR.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset. Deassertion is synchronised externally.
- key_we  in  1  round-key write strobe.
- key_addr  in  4  round-key index. Writes with key_addr > NR are ignored.
- key_wdata  in  128  round key. Bits [127:120] hold byte 0 (column-major, same as the state).
- key_clear  in  1  one-cycle pulse that invalidates all stored keys.
- key_ready  out  1  high when all NR+1 keys have been written since the last reset or key_clear.
- in_valid  in  1  in_state and in_first are valid this cycle.
- in_ready  out  1  stage can accept a beat this cycle.
- in_state  in  128  plaintext (round 0) or MixColumns/ShiftRows output (rounds 1..NR).
- in_first  in  1  marks the round-0 beat of a new block.
- out_valid  out  1  out_state is valid.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  in_state XOR rk[round].
- out_round  out  4  round index used for this result.
- out_final  out  1  out_round == NR, so out_state is ciphertext.
- err  out  1  one-cycle pulse when a protocol-violating beat is dropped.

## Operation
- Key store: NR+1 × 128-bit registers, each with a valid bit. key_ready = AND of the valid bits.
- A write sets the addressed valid bit. key_clear clears all valid bits but leaves the data alone. If key_clear and key_we occur in the same cycle, key_clear wins.
- A key write in the same cycle as a beat that reads the same index: the beat uses the old key (read before write).
- FSM states:
  - IDLE: waiting for a first beat.
  - RUN: round counter rnd holds the index of the next beat, 1..NR.
- IDLE transitions:
  - Beat with in_first=1 is accepted only when key_ready=1. It uses rk[0] and moves to RUN with rnd=1.
  - Beat with in_first=0 is accepted and dropped. err pulses and the state stays IDLE.
- RUN transitions:
  - Beat with in_first=0 uses rk[rnd]. If rnd==NR, go to IDLE; otherwise rnd increments.
  - Beat with in_first=1 aborts the current block. It is treated as a new round-0 beat: rk[0] is used, rnd=1, err pulses.
- key_clear in RUN: the FSM returns to IDLE. No beat is accepted in that cycle.
- Arithmetic: plain 128-bit XOR with no width changes. rnd is 4 bits and never exceeds NR.

## Timing
- Reset values: out_valid=0, out_state=0, out_round=0, out_final=0, err=0, key_ready=0. FSM=IDLE, rnd=0, all valid bits=0.
- Handshake: a beat transfers when in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !(state==IDLE && !key_ready && in_first) && !key_clear.
  - This allows full throughput: one beat per cycle with no bubble when out_ready stays high.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N; out_valid is high in cycle N+1.
- Output hold: out_state, out_round and out_final stay stable while out_valid && !out_ready.
- Dropped beats: err is registered and goes high in the cycle after the drop. A dropped beat never sets out_valid.
- Reset mid-block: the pending output is discarded and all keys are invalidated. The host must reload keys.

## Structure
- Shared package aes_pkg holds:
  - AES_NR = 10
  - STATE_W = 128
  - the FSM enum {IDLE, RUN}
  - the rk_idx_t typedef (4 bits)
- One sub-module, aes_rk_store: the key register file, valid bits, key_ready and the asynchronous read port. The FSM, the XOR and the output register stay in the top level.

## Test plan
- Load the FIPS-197 key 000102030405060708090a0b0c0d0e0f as rk[0] and fill rk[1..10]. Send a first beat of 00112233445566778899aabbccddeeff -> out_state=00102030405060708090a0b0c0d0e0f0, out_round=0, out_final=0, one cycle later.
- Load keys rk[i] = {16{i}} bytes. Send 11 back-to-back beats of zero with out_ready=1 -> outputs rk[0]..rk[10] on consecutive cycles, out_final only on the 11th, and the FSM returns to IDLE.
- Hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 after the first beat, out_state stays stable, and no beat is lost or duplicated.
- Leave rk[5] unwritten and send a first beat -> in_ready=0 and key_ready=0. Write rk[5] -> the beat is accepted on the next cycle.
- Send a beat with in_first=0 while IDLE -> err pulses once and out_valid stays 0. Send in_first=1 at round 4 -> err pulses and out_round=0.
- Write rk[3] in the same cycle a round-3 beat is accepted -> the old key is used, and the next block uses the new key. Assert rst_n low mid-block -> all outputs go to their reset values and key_ready=0.
